// File: rtl/fir_out_conditioner.sv
// FIR output conditioner: decimate, round-half-up scale, saturate, then buffer
// results in a show-ahead FIFO behind a ready/valid interface with drop accounting.
module fir_out_conditioner #(
  parameter int unsigned INPUT_WIDTH    = 26,
  parameter int unsigned OUTPUT_WIDTH   = 16,
  parameter int unsigned SHIFT          = 10,
  parameter int unsigned DECIM          = 1,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic [INPUT_WIDTH-1:0]    din,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [OUTPUT_WIDTH-1:0]   dout,
  input  logic                      clr_flags,
  output logic                      sat_flag,
  output logic                      ovf_flag,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

  localparam int unsigned PHASE_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned SUM_W   = INPUT_WIDTH + 1;
  localparam int unsigned EXT_W   = (SUM_W > OUTPUT_WIDTH) ? SUM_W : OUTPUT_WIDTH;

  localparam logic [SUM_W-1:0] RND_HALF = {{INPUT_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [EXT_W-1:0] SAT_MAX =
    {{(EXT_W - OUTPUT_WIDTH + 1){1'b0}}, {(OUTPUT_WIDTH - 1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN =
    {{(EXT_W - OUTPUT_WIDTH + 1){1'b1}}, {(OUTPUT_WIDTH - 1){1'b0}}};
  localparam logic [OUTPUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUTPUT_WIDTH - 1){1'b1}}};
  localparam logic [OUTPUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUTPUT_WIDTH - 1){1'b0}}};

  logic [PHASE_W-1:0]        phase_q, phase_d;
  logic                      stg_valid_q, stg_valid_d;
  logic [OUTPUT_WIDTH-1:0]   stg_data_q, stg_data_d;
  logic                      stg_sat_q, stg_sat_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      valid_out_d;
  logic [OUTPUT_WIDTH-1:0]   dout_d;
  logic                      sat_flag_d;
  logic                      ovf_flag_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_d;
  logic [OUTPUT_WIDTH-1:0]   mem [FIFO_DEPTH];

  logic signed [SUM_W-1:0]   sum_c;
  logic signed [SUM_W-1:0]   shifted_c;
  logic signed [EXT_W-1:0]   ext_c;
  logic [OUTPUT_WIDTH-1:0]   rnd_val_c;
  logic                      rnd_sat_c;
  logic                      keep_c, pop_c, full_c, push_c, drop_c;
  logic [OUTPUT_WIDTH-1:0]   head_c;

  // Round half toward +inf, then clamp into the output range.
  always_comb begin
    sum_c     = $signed({din[INPUT_WIDTH-1], din}) + $signed(RND_HALF);
    shifted_c = sum_c >>> SHIFT;
    ext_c     = EXT_W'(shifted_c);
    rnd_val_c = OUTPUT_WIDTH'(ext_c);
    rnd_sat_c = 1'b0;
    if (ext_c > SAT_MAX) begin
      rnd_val_c = OUT_MAX;
      rnd_sat_c = 1'b1;
    end else if (ext_c < SAT_MIN) begin
      rnd_val_c = OUT_MIN;
      rnd_sat_c = 1'b1;
    end
  end

  // Next-state logic for decimator, stage register, FIFO and flags.
  always_comb begin
    phase_d     = phase_q;
    stg_valid_d = 1'b0;
    stg_data_d  = rnd_val_c;
    stg_sat_d   = rnd_sat_c;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    dout_d      = dout;
    sat_flag_d  = sat_flag;
    ovf_flag_d  = ovf_flag;
    drop_cnt_d  = drop_cnt;
    head_c      = mem[rd_ptr_q];

    keep_c = valid_in && (phase_q == '0);
    if (valid_in) begin
      phase_d = (phase_q == PHASE_W'(DECIM - 1)) ? '0 : phase_q + PHASE_W'(1);
    end
    stg_valid_d = keep_c;

    pop_c  = valid_out && ready_out;
    full_c = (count_q == CNT_W'(FIFO_DEPTH));
    push_c = stg_valid_q && (!full_c || pop_c);
    drop_c = stg_valid_q && full_c && !pop_c;

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // New head may be the entry being written this edge.
    if (push_c && (rd_ptr_d == wr_ptr_q)) head_c = stg_data_q;
    else                                  head_c = mem[rd_ptr_d];
    valid_out_d = (count_d != '0);
    if (valid_out_d) dout_d = head_c;

    if (clr_flags) begin
      sat_flag_d = 1'b0;
      ovf_flag_d = 1'b0;
      drop_cnt_d = '0;
    end
    if (push_c && stg_sat_q) sat_flag_d = 1'b1;
    if (drop_c) begin
      ovf_flag_d = 1'b1;
      if (drop_cnt_d != '1) drop_cnt_d = drop_cnt_d + DROP_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q     <= '0;
      stg_valid_q <= 1'b0;
      stg_data_q  <= '0;
      stg_sat_q   <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      valid_out   <= 1'b0;
      dout        <= '0;
      sat_flag    <= 1'b0;
      ovf_flag    <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      phase_q     <= phase_d;
      stg_valid_q <= stg_valid_d;
      stg_data_q  <= stg_data_d;
      stg_sat_q   <= stg_sat_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      valid_out   <= valid_out_d;
      dout        <= dout_d;
      sat_flag    <= sat_flag_d;
      ovf_flag    <= ovf_flag_d;
      drop_cnt    <= drop_cnt_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (rst && push_c) mem[wr_ptr_q] <= stg_data_q;
  end

endmodule
